// File: rtl/display_scan_controller.sv
// 4-digit multiplexed display scanner: one-hot digit select, PWM/blink anode drive, slot strobe.
// Optional SCAN_GUARD_EN: blanks the anodes for the first two cycles of every slot (anti-ghosting).
module display_scan_controller #(
  parameter int PRESCALE_W   = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] brightness,
  input  logic [3:0] blink_mask,
  output logic [3:0] selector,
  output logic [3:0] anode_n,
  output logic       slot_start,
  output logic       blink_phase
);

  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PRESCALE_W-1:0] SLOT_LAST  = {PRESCALE_W{1'b1}};
  localparam logic [FW-1:0]         FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [PRESCALE_W-1:0] slot_cnt_r;
  logic [3:0]            selector_r;
  logic [3:0]            anode_n_r;
  logic                  slot_start_r;
  logic [FW-1:0]         frame_cnt_r;
  logic                  blink_phase_r;

  logic wrap_s;
  logic frame_end_s;
  logic blink_toggle_s;
  logic duty_s;
  logic blank_s;
  logic lit_s;

  // A corrupted (non one-hot) selector recovers to digit 0 instead of staying dark.
  function automatic logic [3:0] rotate_sel(input logic [3:0] s);
    if ($onehot(s)) begin
      rotate_sel = {s[2:0], s[3]};
    end else begin
      rotate_sel = 4'b0001;
    end
  endfunction

  // Slot/frame events and the combinational lit decision for the next anode update.
  always_comb begin
    wrap_s         = enable & (slot_cnt_r == SLOT_LAST);
    frame_end_s    = wrap_s & selector_r[3];
    blink_toggle_s = frame_end_s & (frame_cnt_r == FRAME_LAST);
    duty_s         = (slot_cnt_r[PRESCALE_W-1 -: 3] <= brightness);
    blank_s        = blink_phase_r & (|(blink_mask & selector_r));
`ifdef SCAN_GUARD_EN
    lit_s          = enable & duty_s & ~blank_s & (slot_cnt_r >= PRESCALE_W'(2));
`else
    lit_s          = enable & duty_s & ~blank_s;
`endif
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_cnt_r    <= '0;
      selector_r    <= 4'b0001;
      anode_n_r     <= 4'b1111;
      slot_start_r  <= 1'b0;
      frame_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
    end else begin
      slot_start_r <= wrap_s;
      anode_n_r    <= lit_s ? ~selector_r : 4'b1111;
      if (enable) begin
        slot_cnt_r <= slot_cnt_r + PRESCALE_W'(1);
      end
      if (wrap_s) begin
        selector_r <= rotate_sel(selector_r);
      end
      // Blink phase flips on the frame that completes the blink half-period.
      if (frame_end_s) begin
        if (blink_toggle_s) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FW'(1);
        end
      end
    end
  end

  assign selector    = selector_r;
  assign anode_n     = anode_n_r;
  assign slot_start  = slot_start_r;
  assign blink_phase = blink_phase_r;

endmodule
